// File: rtl/spi_slave_regs_if.sv
// ---------------------------------------------------------------------------
// spi_slave_regs_if
// Purpose : groups the four SPI wires between an SPI master and the
//           spi_slave_regs block.
// Signals : SCLK  - SPI clock from the master (asynchronous to clk)
//           MOSI  - serial data master -> slave, MSB first
//           SS    - active-low slave select
//           MISO  - serial data slave -> master, MSB first
// Modports: master (drives SCLK/MOSI/SS, reads MISO)
//           slave  (reads SCLK/MOSI/SS, drives MISO)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_slave_regs_if;
  logic SCLK;
  logic MOSI;
  logic SS;
  logic MISO;

  modport master (output SCLK, output MOSI, output SS, input MISO);
  modport slave  (input SCLK, input MOSI, input SS, output MISO);
endinterface

// File: rtl/spi_slave_regs.sv
// ---------------------------------------------------------------------------
// spi_slave_regs
// Purpose : SPI slave, all four cpol/cpha modes, fronting a 4 x 8-bit
//           register file. First byte of a burst is a command:
//           bit7 = W (1 write, 0 read), bits[1:0] = start address.
//           Following bytes are written to / read from reg[ptr] with the
//           pointer auto-incrementing modulo 4.
// Ports   : clk      - system clock, all state on its rising edge
//           reset    - asynchronous active-low reset
//           cpol     - SCLK idle level
//           cpha     - 0: sample on leading edge, 1: sample on trailing edge
//           spi      - SCLK/MOSI/SS in, MISO out (slave modport)
//           reg_out  - register file, reg[n] on bits [8n+7:8n]
//           rx_data  - last completed byte received (commands included)
//           rx_valid - one-clk pulse per completed byte
//           busy     - high while synchronized SS is low
// Options : define SPI_SLAVE_MISO_TRI_EN to float MISO whenever the slave
//           is not selected or reset is asserted; otherwise MISO is always
//           driven (0 when not selected).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_slave_regs (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpol,
  input  logic              cpha,
  spi_slave_regs_if.slave   spi,
  output logic [31:0]       reg_out,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  // Synchronizers (third SCLK/SS stage is the "previous" sample for edges)
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic mosi_s1_q, mosi_s2_q;
  logic ss_s1_q, ss_s2_q, ss_s3_q;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0][7:0] regs_q, regs_d;

  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       selected, active, sample_edge, shift_edge, ss_fall, byte_done;
  logic [7:0] rx_byte;
  logic [1:0] ptr_inc;
  logic       miso_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s1_q <= cpol;
      sclk_s2_q <= cpol;
      sclk_s3_q <= cpol;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_s3_q   <= 1'b1;
    end else begin
      sclk_s1_q <= spi.SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= spi.MOSI;
      mosi_s2_q <= mosi_s1_q;
      ss_s1_q   <= spi.SS;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
    end
  end

  assign sclk_rise  = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall  = ~sclk_s2_q & sclk_s3_q;
  assign lead_edge  = cpol ? sclk_fall : sclk_rise;
  assign trail_edge = cpol ? sclk_rise : sclk_fall;
  assign selected   = ~ss_s2_q;
  assign ss_fall    = ss_s3_q & ~ss_s2_q;

  // Edges count whenever a burst is open. The FSM leaves IDLE only on an SS
  // fall and returns one clk after SS rises, so an edge that lands on the
  // same clk as the SS rise still completes its byte.
  assign active      = (state_q != IDLE);
  assign sample_edge = active & (cpha ? trail_edge : lead_edge);
  assign shift_edge  = active & (cpha ? lead_edge : trail_edge);
  assign rx_byte     = {rx_sh_q[6:0], mosi_s2_q};
  assign byte_done   = sample_edge & (bit_cnt_q == 3'd7);
  assign ptr_inc     = ptr_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ptr_d      = ptr_q;
    regs_d     = regs_q;

    if (sample_edge) begin
      rx_sh_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // The first shift edge after a load (bit counter still 0) would push
    // bit7 out before the master samples it, so it is skipped.
    if (shift_edge && (state_q == RDATA) && (bit_cnt_q != 3'd0)) begin
      tx_sh_d = {tx_sh_q[6:0], 1'b0};
    end

    if (byte_done) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
      case (state_q)
        CMD: begin
          ptr_d = rx_byte[1:0];
          if (rx_byte[7]) begin
            state_d = WDATA;
          end else begin
            state_d = RDATA;
            tx_sh_d = regs_q[rx_byte[1:0]];
          end
        end
        WDATA: begin
          regs_d[ptr_q] = rx_byte;
          ptr_d         = ptr_inc;
        end
        RDATA: begin
          ptr_d   = ptr_inc;
          tx_sh_d = regs_q[ptr_inc];
        end
        default: ;
      endcase
    end

    // SS handling overrides the framing state but leaves a just-completed
    // write and its rx_valid intact.
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        rx_sh_d   = 8'h00;
        tx_sh_d   = 8'h00;
      end
    end else if (!selected) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      rx_sh_d   = 8'h00;
      tx_sh_d   = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      rx_sh_q    <= 8'h00;
      tx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ptr_q      <= 2'd0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
    end
  end

  assign miso_bit = ((state_q == RDATA) && selected) ? tx_sh_q[7] : 1'b0;

`ifdef SPI_SLAVE_MISO_TRI_EN
  assign spi.MISO = (!reset || ss_s2_q) ? 1'bz : miso_bit;
`else
  assign spi.MISO = miso_bit;
`endif

  assign reg_out  = regs_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = ~ss_s2_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
`timescale 1ns/1ps
module tb_spi_slave_regs;

  logic        clk;
  logic        reset;
  logic        cpol;
  logic        cpha;
  logic [31:0] reg_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  int rv_cnt  = 0;
  int rv_snap;
  logic [7:0] r0, r1, r2;

  spi_slave_regs_if spi_bus ();

  spi_slave_regs dut (
    .clk      (clk),
    .reset    (reset),
    .cpol     (cpol),
    .cpha     (cpha),
    .spi      (spi_bus.slave),
    .reg_out  (reg_out),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

`ifdef SPI_SLAVE_MISO_TRI_EN
  localparam logic MISO_OFF = 1'bz;
`else
  localparam logic MISO_OFF = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rx_valid === 1'b1) rv_cnt <= rv_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One SPI byte (or its first nbits bits), SCLK = clk/100.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        spi_bus.MOSI = tx[i];
        #500;
        spi_bus.SCLK = ~cpol;
        rx[i] = spi_bus.MISO;
        #500;
        spi_bus.SCLK = cpol;
      end else begin
        spi_bus.SCLK = ~cpol;
        spi_bus.MOSI = tx[i];
        #500;
        spi_bus.SCLK = cpol;
        rx[i] = spi_bus.MISO;
        #500;
      end
    end
  endtask

  task automatic ss_low;
    spi_bus.SS = 1'b0;
    #500;
  endtask

  task automatic ss_high;
    #500;
    spi_bus.SS = 1'b1;
    #500;
  endtask

  task automatic burst3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    ss_low();
    xfer(a, 8, r0);
    xfer(b, 8, r1);
    xfer(c, 8, r2);
    ss_high();
  endtask

  initial begin
    reset        = 1'b0;
    cpol         = 1'b0;
    cpha         = 1'b0;
    spi_bus.SCLK = 1'b0;
    spi_bus.MOSI = 1'b0;
    spi_bus.SS   = 1'b1;
    #103;

    // Reset state
    chk("rst_reg_out",  reg_out,  32'h0);
    chk("rst_rx_data",  rx_data,  32'h0);
    chk("rst_rx_valid", rx_valid, 32'h0);
    chk("rst_busy",     busy,     32'h0);
    chk("rst_miso",     spi_bus.MISO, MISO_OFF);
    reset = 1'b1;
    #200;

    // Mode 0 write burst: cmd 0x81 -> reg1, reg2
    rv_snap = rv_cnt;
    ss_low();
    chk("busy_selected", busy, 32'h1);
    xfer(8'h81, 8, r0);
    xfer(8'hA5, 8, r1);
    xfer(8'h3C, 8, r2);
    ss_high();
    chk("wr_reg1",      reg_out[15:8],  32'hA5);
    chk("wr_reg2",      reg_out[23:16], 32'h3C);
    chk("wr_reg0_reg3", {reg_out[31:24], reg_out[7:0]}, 32'h0);
    chk("wr_rv_pulses", rv_cnt - rv_snap, 32'd3);
    chk("wr_rx_data",   rx_data, 32'h3C);
    chk("wr_miso_zero", {r0, r1, r2}, 32'h0);
    chk("busy_released", busy, 32'h0);

    // Preload reg3/reg0 with wrap, then read back from address 3
    burst3(8'h83, 8'h11, 8'h22);
    chk("pre_reg_out", reg_out, 32'h113CA522);
    burst3(8'h03, 8'h00, 8'h00);
    chk("rd_cmd_miso", r0, 32'h00);
    chk("rd_byte0",    r1, 32'h11);
    chk("rd_byte1",    r2, 32'h22);
    chk("rd_no_modify", reg_out, 32'h113CA522);

    // All four modes: clear reg0, write 0x5A, read it back
    for (int m = 0; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      spi_bus.SCLK = m[1];
      #500;
      ss_low();
      xfer(8'h80, 8, r0);
      xfer(8'h00, 8, r1);
      ss_high();
      chk($sformatf("mode%0d_reg0_clear", m), reg_out[7:0], 32'h00);
      ss_low();
      xfer(8'h80, 8, r0);
      xfer(8'h5A, 8, r1);
      ss_high();
      chk($sformatf("mode%0d_reg0_write", m), reg_out[7:0], 32'h5A);
      ss_low();
      xfer(8'h00, 8, r0);
      xfer(8'h00, 8, r1);
      ss_high();
      chk($sformatf("mode%0d_reg0_read", m), r1, 32'h5A);
    end
    chk("modes_other_regs", reg_out[31:8], 32'h113CA5);

    // Partial byte then SS high
    cpol = 1'b0;
    cpha = 1'b0;
    spi_bus.SCLK = 1'b0;
    #500;
    rv_snap = rv_cnt;
    ss_low();
    xfer(8'h82, 8, r0);
    xfer(8'hFF, 4, r1);
    ss_high();
    chk("part_reg_out",  reg_out, 32'h113CA55A);
    chk("part_rv_pulses", rv_cnt - rv_snap, 32'd1);
    chk("part_rx_data",  rx_data, 32'h82);
    chk("part_idle",     dut.state_q, 32'd0);
    chk("part_busy",     busy, 32'h0);

    // Reset during the 5th bit of a write data byte
    ss_low();
    xfer(8'h80, 8, r0);
    xfer(8'hFF, 4, r1);
    spi_bus.MOSI = 1'b1;
    #250;
    reset = 1'b0;
    #20;
    chk("midrst_reg_out",  reg_out,  32'h0);
    chk("midrst_rx_data",  rx_data,  32'h0);
    chk("midrst_rx_valid", rx_valid, 32'h0);
    chk("midrst_busy",     busy,     32'h0);
    chk("midrst_miso",     spi_bus.MISO, MISO_OFF);
    chk("midrst_idle",     dut.state_q, 32'd0);
    spi_bus.SS   = 1'b1;
    spi_bus.SCLK = 1'b0;
    #100;
    reset = 1'b1;
    #500;
    ss_low();
    xfer(8'h80, 8, r0);
    xfer(8'h77, 8, r1);
    ss_high();
    chk("postrst_reg_out", reg_out, 32'h00000077);

    // SCLK toggling while not selected
    rv_snap = rv_cnt;
    for (int i = 0; i < 20; i++) begin
      spi_bus.MOSI = 1'($urandom_range(0, 1));
      spi_bus.SCLK = ~spi_bus.SCLK;
      #500;
    end
    spi_bus.SCLK = 1'b0;
    #500;
    chk("dsel_reg_out",   reg_out, 32'h00000077);
    chk("dsel_rv_pulses", rv_cnt - rv_snap, 32'd0);
    chk("dsel_rx_data",   rx_data, 32'h77);
    chk("dsel_busy",      busy, 32'h0);
    chk("dsel_idle",      dut.state_q, 32'd0);
    chk("dsel_miso",      spi_bus.MISO, MISO_OFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
